id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID->EX pipeline register and the consumer of the hazard handler's outputs.
//  - Applies rs1_hzd/rs2_hzd forwarding selects to the register-file read data.
//  - Honours stall by injecting a bubble into EX.
//  - Honours flush from branch resolution.
//  - Registers the forwarded operands and control for the EX stage.
// PARAMETERS
//  XLEN    32  operand/result width
//  CTRL_W  16  opaque EX/M/WB control bundle width, passed through untouched
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       synchronous active-low reset
//  id_valid     in   1       ID holds a real instruction
//  id_rs1       in   5       source register 1 index
//  id_rs2       in   5       source register 2 index
//  id_rs1_data  in   XLEN    regfile read data for rs1
//  id_rs2_data  in   XLEN    regfile read data for rs2
//  id_rd        in   5       destination index
//  id_rw        in   1       instruction writes rd
//  id_MREQ      in   1       instruction is a load
//  id_imm       in   XLEN    decoded immediate
//  id_ctrl      in   CTRL_W  control bundle
//  rs1_hzd      in   2       {wb_hit, mem_hit} for rs1
//  rs2_hzd      in   2       {wb_hit, mem_hit} for rs2
//  stall        in   1       load-use stall request
//  flush        in   1       kill the instruction in ID
//  ex_fwd_data  in   XLEN    result of the instruction now in EX
//  m_fwd_data   in   XLEN    result of the instruction now in M
//  id_hold      out  1       freeze PC and IF/ID; equals stall & ~flush
//  ex_valid     out  1       EX slot holds a real instruction
//  ex_rs1_val   out  XLEN    registered operand 1
//  ex_rs2_val   out  XLEN    registered operand 2
//  ex_imm       out  XLEN    registered immediate
//  ex_rd        out  5       registered rd
//  ex_rw        out  1       registered write enable
//  ex_MREQ      out  1       registered load flag
//  ex_ctrl      out  CTRL_W  registered control bundle
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): all ex_* outputs are 0. id_hold is combinational and follows stall & ~flush.
//  - Operand select, combinational, per source:
//    - rs==0 -> 0. The x0 mask is applied here, because the hazard unit does not mask x0.
//    - else hzd[0] -> ex_fwd_data. The newest producer wins when both bits are set.
//    - else hzd[1] -> m_fwd_data.
//    - else rs*_data.
//  - Per posedge, priority order:
//    1. reset.
//    2. flush or stall or ~id_valid: bubble. ex_valid=0, ex_rw=0, ex_MREQ=0, ex_ctrl=0; data fields are don't-care and are held.
//    3. else: load all ex_* from ID, using the forwarded operands. ex_valid=1.
//  - Latency: one cycle ID->EX. Forwarded values are sampled in the same cycle as the select.
//  - Stall sequence: the held ID instruction is re-evaluated next cycle.
//    - The load has then moved to M, so the hazard becomes hzd[1] and operands come from m_fwd_data.
//    - The stage holds no local operand state across a stall.
//  - flush+stall in the same cycle: flush wins. Bubble is inserted and id_hold=0, so fetch redirects.
//  - Reset mid-stall: bubble state; no residual hold.
// CONFIGURATION
//  HZD_STATS_EN defined adds three outputs, cleared on reset:
//    - stall_cnt [31:0]: +1 per cycle with id_hold=1.
//    - fwd_ex_cnt [31:0]: +1 per issued instruction using an EX forward on any operand.
//    - fwd_m_cnt [31:0]: +1 per issued instruction using an M forward on any operand.
//    - All three saturate at 32'hFFFF_FFFF.
//  HZD_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. No-hazard issue: rs1=3, rs2=4, data 11/22, hzd=00 -> next cycle ex_rs1_val=11, ex_rs2_val=22, ex_valid=1.
//  2. Double hazard: hzd1=11, ex_fwd=0xAA, m_fwd=0xBB -> ex_rs1_val=0xAA (EX priority).
//  3. x0 guard: rs1=0, hzd1=01, ex_fwd=0x55 -> ex_rs1_val=0.
//  4. Load-use: stall=1 for 1 cycle -> id_hold=1, ex_valid=0 next cycle; then hzd=10 -> ex_rs1_val=m_fwd_data.
//  5. flush+stall together -> id_hold=0, ex_valid=0, ex_rw=0, ex_MREQ=0.
//  6. Reset pulsed mid-stream -> all ex_* =0 next edge. With HZD_STATS_EN: counters read 0; 3 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: forwards operands from EX/M results, inserts bubbles on stall/flush.
// Optional HZD_STATS_EN macro adds saturating stall/forwarding counters.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [4:0]        id_rd,
    input  logic              id_rw,
    input  logic              id_MREQ,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [1:0]        rs1_hzd,
    input  logic [1:0]        rs2_hzd,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic [XLEN-1:0]   m_fwd_data,
    output logic              id_hold,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_rw,
    output logic              ex_MREQ,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef HZD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_ex_cnt,
    output logic [31:0]       fwd_m_cnt
`endif
);

    // x0 is masked here because the hazard unit raises hits for x0 too.
    function automatic logic [XLEN-1:0] op_sel(input logic [4:0] rs, input logic [1:0] hzd,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] exd,
                                               input logic [XLEN-1:0] md);
        if (rs == 5'd0)  return '0;
        else if (hzd[0]) return exd;
        else if (hzd[1]) return md;
        else             return rf;
    endfunction

    logic              bubble;
    logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

    logic              valid_d, rw_d, mreq_d;
    logic [XLEN-1:0]   rs1_d, rs2_d, imm_d;
    logic [4:0]        rd_d;
    logic [CTRL_W-1:0] ctrl_d;

    logic              valid_q, rw_q, mreq_q;
    logic [XLEN-1:0]   rs1_q, rs2_q, imm_q;
    logic [4:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;

    assign id_hold = stall & ~flush;
    assign bubble  = flush | stall | ~id_valid;
    assign rs1_fwd = op_sel(id_rs1, rs1_hzd, id_rs1_data, ex_fwd_data, m_fwd_data);
    assign rs2_fwd = op_sel(id_rs2, rs2_hzd, id_rs2_data, ex_fwd_data, m_fwd_data);

    always_comb begin
        valid_d = 1'b0;
        rw_d    = 1'b0;
        mreq_d  = 1'b0;
        ctrl_d  = '0;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        if (!bubble) begin
            valid_d = 1'b1;
            rw_d    = id_rw;
            mreq_d  = id_MREQ;
            ctrl_d  = id_ctrl;
            rs1_d   = rs1_fwd;
            rs2_d   = rs2_fwd;
            imm_d   = id_imm;
            rd_d    = id_rd;
        end
    end

    // ID -> EX register boundary
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mreq_q  <= 1'b0;
            ctrl_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            mreq_q  <= mreq_d;
            ctrl_q  <= ctrl_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_rw      = rw_q;
    assign ex_MREQ    = mreq_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_rs1_val = rs1_q;
    assign ex_rs2_val = rs2_q;
    assign ex_imm     = imm_q;
    assign ex_rd      = rd_q;

`ifdef HZD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        use_ex, use_m;
    logic [31:0] stall_cnt_q, fwd_ex_cnt_q, fwd_m_cnt_q;
    logic [31:0] stall_cnt_d, fwd_ex_cnt_d, fwd_m_cnt_d;

    // A forward only counts when it actually drives the operand (x0 and EX priority respected).
    assign use_ex = ((id_rs1 != 5'd0) && rs1_hzd[0]) || ((id_rs2 != 5'd0) && rs2_hzd[0]);
    assign use_m  = ((id_rs1 != 5'd0) && (rs1_hzd == 2'b10)) ||
                    ((id_rs2 != 5'd0) && (rs2_hzd == 2'b10));

    always_comb begin
        stall_cnt_d  = id_hold ? sat_inc(stall_cnt_q) : stall_cnt_q;
        fwd_ex_cnt_d = (!bubble && use_ex) ? sat_inc(fwd_ex_cnt_q) : fwd_ex_cnt_q;
        fwd_m_cnt_d  = (!bubble && use_m) ? sat_inc(fwd_m_cnt_q) : fwd_m_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            fwd_ex_cnt_q <= '0;
            fwd_m_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            fwd_ex_cnt_q <= fwd_ex_cnt_d;
            fwd_m_cnt_q  <= fwd_m_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign fwd_ex_cnt = fwd_ex_cnt_q;
    assign fwd_m_cnt  = fwd_m_cnt_q;
`endif

endmodule
